// File: rtl/mem_init_sequencer.sv
// Memory-initialisation sequencer: walks addresses 0..DEPTH-1 and issues one
// write per word using a selectable data pattern, with abort and multi-cycle strobes.
module mem_init_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_val,
  output logic              wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              finish
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_ADVANCE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [3:0]        CNT_LOAD  = 4'(WR_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Widest of address/data so the identity and xor patterns never lose bits
  localparam int AW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int EW = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        cnt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      cnt    <= '0;
      mode_q <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            fill_q <= fill_val;
            addr   <= '0;
            cnt    <= CNT_LOAD;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (abort) begin
            addr  <= '0;
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_ADVANCE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ADVANCE: begin
          // Abort takes priority even on the final word, suppressing finish
          if (abort) begin
            addr  <= '0;
            state <= S_IDLE;
          end else if (addr == LAST_ADDR) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            cnt   <= CNT_LOAD;
            state <= S_WRITE;
          end
        end
        S_DONE: begin
          addr  <= '0;
          state <= S_IDLE;
        end
        default: begin
          addr  <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic [AW-1:0]     a_ext;
  logic [AW-1:0]     fill_ext;
  logic [AW-1:0]     xor_ext;
  logic [ADDR_W:0]   desc;
  logic [EW-1:0]     desc_ext;

  assign a_ext    = AW'(addr);
  assign fill_ext = AW'(fill_q);
  assign xor_ext  = a_ext ^ fill_ext;
  assign desc     = (ADDR_W + 1)'(DEPTH - 1) - {1'b0, addr};
  assign desc_ext = EW'(desc);

  always_comb begin
    wr_data = '0;
    case (mode_q)
      2'b00:   wr_data = a_ext[DATA_W-1:0];
      2'b01:   wr_data = fill_q;
      2'b10:   wr_data = desc_ext[DATA_W-1:0];
      default: wr_data = xor_ext[DATA_W-1:0];
    endcase
  end

  assign wr_en    = (state == S_WRITE);
  assign busy     = (state == S_WRITE) || (state == S_ADVANCE);
  assign finish   = (state == S_DONE);
  assign mem_addr = addr;

endmodule

// File: tb/tb_mem_init_sequencer.sv
// Directed bench for mem_init_sequencer: three instances covering the identity,
// multi-cycle strobe and narrow-address descending configurations.
module tb_mem_init_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] start;
  logic [2:0] abort;
  logic [1:0] mode;
  logic [7:0] fill;

  wire  [2:0] wr;
  wire  [2:0] bsy;
  wire  [2:0] fin;
  wire  [7:0] addr_a;
  wire  [7:0] addr_b;
  wire  [3:0] addr_c;
  wire  [7:0] data_a;
  wire  [7:0] data_b;
  wire  [7:0] data_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_init_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WR_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .mode(mode),
    .fill_val(fill), .wr_en(wr[0]), .mem_addr(addr_a), .wr_data(data_a),
    .busy(bsy[0]), .finish(fin[0]));

  mem_init_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WR_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .mode(mode),
    .fill_val(fill), .wr_en(wr[1]), .mem_addr(addr_b), .wr_data(data_b),
    .busy(bsy[1]), .finish(fin[1]));

  mem_init_sequencer #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WR_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .mode(mode),
    .fill_val(fill), .wr_en(wr[2]), .mem_addr(addr_c), .wr_data(data_c),
    .busy(bsy[2]), .finish(fin[2]));

  function automatic logic [31:0] get_addr(input int d);
    case (d)
      0:       return 32'(addr_a);
      1:       return 32'(addr_b);
      default: return 32'(addr_c);
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int d);
    case (d)
      0:       return 32'(data_a);
      1:       return 32'(data_b);
      default: return 32'(data_c);
    endcase
  endfunction

  // RAM model and strobe statistics, sampled on the falling edge
  logic [7:0] ram [3][256];
  int         wcnt [3];
  int         first_addr [3];
  int         run_len [3];
  int         min_w [3];
  int         max_w [3];
  logic       prev [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (wr[d] === 1'b1) begin
        ram[d][get_addr(d)] = get_data(d)[7:0];
        if (!prev[d]) begin
          if (wcnt[d] == 0) first_addr[d] = int'(get_addr(d));
          wcnt[d]++;
        end
        run_len[d]++;
        prev[d] = 1'b1;
      end else begin
        if (prev[d]) begin
          if (run_len[d] < min_w[d]) min_w[d] = run_len[d];
          if (run_len[d] > max_w[d]) max_w[d] = run_len[d];
        end
        run_len[d] = 0;
        prev[d] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < 256; i++) ram[d][i] = 'x;
    wcnt[d] = 0;
    first_addr[d] = -1;
    min_w[d] = 1000;
    max_w[d] = 0;
    run_len[d] = 0;
  endtask

  // Returns at the sample point of cycle 1 after the accepting edge
  task automatic go(input int d, input logic [1:0] m, input logic [7:0] f);
    @(negedge clk);
    start[d] = 1'b1;
    mode = m;
    fill = f;
    @(negedge clk);
  endtask

  // Samples cycles 1..ncyc; returns at the sample point of cycle ncyc+1
  task automatic watch(input int d, input int ncyc, input int repulse_at,
                       input int abort_at, output int fin_at, output int fin_cnt);
    fin_at = 0;
    fin_cnt = 0;
    for (int n = 1; n <= ncyc; n++) begin
      if (fin[d] === 1'b1) begin
        if (fin_at == 0) fin_at = n;
        fin_cnt++;
      end
      start[d] = (n == repulse_at);
      abort[d] = (n == abort_at);
      @(negedge clk);
    end
    start[d] = 1'b0;
  endtask

  // kind: 0 identity, 1 constant, 2 descending, 3 xor
  task automatic check_ram(input string tag, input int d, input int kind,
                           input logic [7:0] f, input int depth);
    int bad;
    logic [7:0] exp;
    bad = 0;
    for (int i = 0; i < depth; i++) begin
      case (kind)
        0:       exp = 8'(i);
        1:       exp = f;
        2:       exp = 8'(depth - 1 - i);
        default: exp = 8'(i) ^ f;
      endcase
      if (ram[d][i] !== exp) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int fa;
    int fc;
    start = '0;
    abort = '0;
    mode  = '0;
    fill  = '0;

    // Asynchronous reset before the first clock edge
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_wr%0d", d),   32'(wr[d]),  32'd0);
      check($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'd0);
      check($sformatf("rst_fin%0d", d),  32'(fin[d]), 32'd0);
      check($sformatf("rst_addr%0d", d), get_addr(d), 32'd0);
      check($sformatf("rst_data%0d", d), get_data(d), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("idle_no_wr%0d", d), 32'(wr[d]), 32'd0);

    // Identity run, single-cycle strobes
    clear_model(0);
    go(0, 2'b00, 8'h00);
    check("id_wr_c1", 32'(wr[0]), 32'd1);
    watch(0, 600, 0, 0, fa, fc);
    check("id_fin_at", 32'(fa), 32'd513);
    check("id_fin_cnt", 32'(fc), 32'd1);
    check("id_busy_after", 32'(bsy[0]), 32'd0);
    check("id_addr_after", get_addr(0), 32'd0);
    check("id_wcnt", 32'(wcnt[0]), 32'd256);
    check("id_min_w", 32'(min_w[0]), 32'd1);
    check("id_max_w", 32'(max_w[0]), 32'd1);
    check_ram("id_ram", 0, 0, 8'h00, 256);

    // Start re-pulsed during word 5 must be ignored
    clear_model(0);
    go(0, 2'b00, 8'h00);
    watch(0, 600, 11, 0, fa, fc);
    check("rep_fin_at", 32'(fa), 32'd513);
    check("rep_fin_cnt", 32'(fc), 32'd1);
    check("rep_wcnt", 32'(wcnt[0]), 32'd256);

    // Abort during the write of word 40
    clear_model(0);
    go(0, 2'b00, 8'h00);
    watch(0, 81, 0, 81, fa, fc);
    abort[0] = 1'b0;
    check("abt_wr", 32'(wr[0]), 32'd0);
    check("abt_busy", 32'(bsy[0]), 32'd0);
    check("abt_addr", get_addr(0), 32'd0);
    watch(0, 600, 0, 0, fa, fc);
    check("abt_no_fin", 32'(fc), 32'd0);
    check("abt_wcnt", 32'(wcnt[0]), 32'd41);

    // Fresh run after abort, xor pattern
    clear_model(0);
    go(0, 2'b11, 8'h3C);
    watch(0, 600, 0, 0, fa, fc);
    check("fresh_fin_at", 32'(fa), 32'd513);
    check("fresh_first_addr", 32'(first_addr[0]), 32'd0);
    check("fresh_wcnt", 32'(wcnt[0]), 32'd256);
    check_ram("fresh_ram", 0, 3, 8'h3C, 256);

    // Reset during the write of address 0x80
    clear_model(0);
    go(0, 2'b00, 8'h00);
    watch(0, 256, 0, 0, fa, fc);
    check("mid_wr_before", 32'(wr[0]), 32'd1);
    check("mid_addr_before", get_addr(0), 32'h80);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr", 32'(wr[0]), 32'd0);
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    check("mid_rst_addr", get_addr(0), 32'd0);
    check("mid_rst_data", get_data(0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_wcnt", 32'(wcnt[0]), 32'd129);
    clear_model(0);
    go(0, 2'b00, 8'h00);
    watch(0, 600, 0, 0, fa, fc);
    check("post_rst_fin_at", 32'(fa), 32'd513);
    check("post_rst_first_addr", 32'(first_addr[0]), 32'd0);
    check_ram("post_rst_ram", 0, 0, 8'h00, 256);

    // Constant pattern with three-cycle strobes
    clear_model(1);
    go(1, 2'b01, 8'hA5);
    watch(1, 1100, 0, 0, fa, fc);
    check("const_fin_at", 32'(fa), 32'd1025);
    check("const_fin_cnt", 32'(fc), 32'd1);
    check("const_min_w", 32'(min_w[1]), 32'd3);
    check("const_max_w", 32'(max_w[1]), 32'd3);
    check("const_wcnt", 32'(wcnt[1]), 32'd256);
    check_ram("const_ram", 1, 1, 8'hA5, 256);

    // Xor pattern with three-cycle strobes
    clear_model(1);
    go(1, 2'b11, 8'hA5);
    watch(1, 1100, 0, 0, fa, fc);
    check("xor_fin_at", 32'(fa), 32'd1025);
    check("xor_ram_10", 32'(ram[1][16]), 32'hB5);
    check_ram("xor_ram", 1, 3, 8'hA5, 256);

    // Descending on a 4-bit address, 8-bit data instance
    clear_model(2);
    go(2, 2'b10, 8'h5A);
    check("desc_data_c1", get_data(2), 32'h0F);
    watch(2, 40, 0, 0, fa, fc);
    check("desc_fin_at", 32'(fa), 32'd33);
    check("desc_ram_0", 32'(ram[2][0]), 32'h0F);
    check("desc_ram_15", 32'(ram[2][15]), 32'h00);
    check_ram("desc_ram", 2, 2, 8'h00, 16);

    // Start and abort together in IDLE, then abort on the final ADVANCE
    clear_model(2);
    abort[2] = 1'b1;
    go(2, 2'b10, 8'h00);
    check("sa_busy_c1", 32'(bsy[2]), 32'd1);
    watch(2, 32, 0, 32, fa, fc);
    abort[2] = 1'b0;
    check("last_abt_fin", 32'(fin[2]), 32'd0);
    check("last_abt_busy", 32'(bsy[2]), 32'd0);
    check("last_abt_addr", get_addr(2), 32'd0);
    watch(2, 10, 0, 0, fa, fc);
    check("last_abt_no_fin", 32'(fc), 32'd0);
    check("last_abt_wcnt", 32'(wcnt[2]), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
